// File: rtl/demux_pkg.sv
// Shared constants and slot state for the 1-to-4 buffered demux.
// Optional per-channel handshake counters: DEMUX_COUNT_EN.
package demux_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int NUM_OUT   = 4;
    localparam int ADDR_W    = 2;
    localparam int CNT_W     = 16;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_e;

endpackage

// File: rtl/demux_out_slot.sv
// One-entry valid/ready output register; a write while full and
// draining replaces the word with no bubble.
module demux_out_slot
    import demux_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    slot_state_e      r_state;
    logic [WIDTH-1:0] r_data;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= EMPTY;
            r_data  <= '0;
        end else begin
            unique case (r_state)
                EMPTY: begin
                    if (wr_en) begin
                        r_state <= FULL;
                        r_data  <= wr_data;
                    end
                end
                FULL: begin
                    if (wr_en) begin
                        r_data <= wr_data;
                    end else if (ready) begin
                        r_state <= EMPTY;
                    end
                end
                default: r_state <= EMPTY;
            endcase
        end
    end

    assign valid = (r_state == FULL);
    assign data  = r_data;

endmodule

// File: rtl/demux1to4_buf.sv
// Steers one input word to one of four buffered valid/ready channels.
// Build with DEMUX_COUNT_EN to add per-channel handshake counters.
module demux1to4_buf
    import demux_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ADDR_W-1:0]        in_address,
    input  logic [WIDTH-1:0]         in_data,
    output logic [NUM_OUT-1:0]       out_valid,
    input  logic [NUM_OUT-1:0]       out_ready,
`ifdef DEMUX_COUNT_EN
    output logic [NUM_OUT*CNT_W-1:0] out_count,
`endif
    output logic [WIDTH-1:0]         out_data0,
    output logic [WIDTH-1:0]         out_data1,
    output logic [WIDTH-1:0]         out_data2,
    output logic [WIDTH-1:0]         out_data3
);

    logic             w_accept;
    logic [NUM_OUT-1:0] w_wr_en;
    logic [WIDTH-1:0] w_data [NUM_OUT];

    // Only the addressed channel can stall the producer.
    assign in_ready = !out_valid[in_address] | out_ready[in_address];
    assign w_accept = in_valid & in_ready;

    for (genvar k = 0; k < NUM_OUT; k++) begin : g_slot
        assign w_wr_en[k] = w_accept && (in_address == ADDR_W'(k));

        demux_out_slot #(
            .WIDTH(WIDTH)
        ) u_slot (
            .clk    (clk),
            .rst_n  (rst_n),
            .wr_en  (w_wr_en[k]),
            .wr_data(in_data),
            .ready  (out_ready[k]),
            .valid  (out_valid[k]),
            .data   (w_data[k])
        );
    end

    assign out_data0 = w_data[0];
    assign out_data1 = w_data[1];
    assign out_data2 = w_data[2];
    assign out_data3 = w_data[3];

`ifdef DEMUX_COUNT_EN
    logic [CNT_W-1:0] r_cnt [NUM_OUT];

    for (genvar k = 0; k < NUM_OUT; k++) begin : g_cnt
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_cnt[k] <= '0;
            end else if (out_valid[k] && out_ready[k]) begin
                r_cnt[k] <= r_cnt[k] + CNT_W'(1);
            end
        end

        assign out_count[CNT_W*k +: CNT_W] = r_cnt[k];
    end
`endif

endmodule

// File: tb/tb_demux1to4_buf.sv
// Directed and random checks of demux1to4_buf against a queue-style
// model: each channel is a buffer of capacity one.
module tb_demux1to4_buf;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_address;
    logic [31:0] in_data;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [31:0] out_data0;
    logic [31:0] out_data1;
    logic [31:0] out_data2;
    logic [31:0] out_data3;
`ifdef DEMUX_COUNT_EN
    logic [63:0] out_count;
`endif

    int checks = 0;
    int errors = 0;

    // Model: per-channel buffer contents and delivered-word tallies.
    int unsigned buf_q [4][$];
    int unsigned delivered [4];
    int unsigned last_data [4];

    demux1to4_buf dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_address(in_address),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef DEMUX_COUNT_EN
        .out_count (out_count),
`endif
        .out_data0 (out_data0),
        .out_data1 (out_data1),
        .out_data2 (out_data2),
        .out_data3 (out_data3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] dout(input int k);
        case (k)
            0: return out_data0;
            1: return out_data1;
            2: return out_data2;
            default: return out_data3;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < 4; k++) begin
            buf_q[k].delete();
            delivered[k] = 0;
            last_data[k] = 0;
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [3:0] ev;
        for (int k = 0; k < 4; k++) ev[k] = (buf_q[k].size() != 0);
        chk({tag, "_valid"}, {28'd0, out_valid}, {28'd0, ev});
        for (int k = 0; k < 4; k++)
            if (ev[k]) chk($sformatf("%s_data%0d", tag, k), dout(k), buf_q[k][0]);
`ifdef DEMUX_COUNT_EN
        for (int k = 0; k < 4; k++)
            chk($sformatf("%s_cnt%0d", tag, k),
                {16'd0, out_count[16*k +: 16]}, delivered[k] % 65536);
`endif
    endtask

    // One clock: check in_ready mid-cycle, advance model, check outputs.
    task automatic cycle(input string tag, input bit do_chk = 1'b1);
        bit exp_rdy;
        bit drain [4];
        @(negedge clk);
        exp_rdy = (buf_q[in_address].size() == 0) || out_ready[in_address];
        if (do_chk) chk({tag, "_in_ready"}, {31'd0, in_ready}, {31'd0, exp_rdy});
        for (int k = 0; k < 4; k++)
            drain[k] = (buf_q[k].size() != 0) && out_ready[k];
        @(posedge clk);
        #1;
        if (!rst_n) begin
            model_clear();
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (drain[k]) begin
                    void'(buf_q[k].pop_front());
                    delivered[k]++;
                end
            end
            if (in_valid && exp_rdy) begin
                buf_q[in_address].push_back(in_data);
                last_data[in_address] = in_data;
            end
        end
        if (do_chk) check_outputs(tag);
    endtask

    task automatic drive(input bit v, input int a, input int unsigned d,
                         input logic [3:0] r);
        in_valid   = v;
        in_address = 2'(a);
        in_data    = d;
        out_ready  = r;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1, 0, 35, 4'b0000);
        model_clear();
        @(posedge clk);
        #1;

        // Reset held with a word presented: nothing captured.
        cycle("rst_a");
        cycle("rst_b");
        chk("rst_valid", {28'd0, out_valid}, 32'd0);
        for (int k = 0; k < 4; k++) chk($sformatf("rst_d%0d", k), dout(k), 32'd0);
        rst_n = 1'b1;
        drive(0, 0, 0, 4'b1111);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Routing, one word per cycle.
        drive(1, 0, 35, 4'b1111);  cycle("route0");
        chk("route0_oh", {28'd0, out_valid}, 32'b0001);
        drive(1, 1, 27, 4'b1111);  cycle("route1");
        chk("route1_oh", {28'd0, out_valid}, 32'b0010);
        drive(1, 2, 567, 4'b1111); cycle("route2");
        chk("route2_d", out_data2, 32'd567);
        drive(1, 3, 319, 4'b1111); cycle("route3");
        chk("route3_d", out_data3, 32'd319);
        drive(0, 0, 0, 4'b1111);   cycle("route_end");

        // Stall on channel 2, then pass-through replacement.
        drive(1, 2, 193, 4'b1011); cycle("stall_a");
        drive(1, 2, 195, 4'b1011); cycle("stall_b");
        chk("stall_hold", out_data2, 32'd193);
        @(negedge clk);
        chk("stall_blocked", {31'd0, in_ready}, 32'd0);
        drive(1, 2, 195, 4'b1111); cycle("stall_c");
        chk("stall_pass", out_data2, 32'd195);

        // Channel 2 stalled full does not block channel 1.
        drive(1, 1, 688, 4'b1011); cycle("indep");
        chk("indep_d1", out_data1, 32'd688);
        chk("indep_d2", out_data2, 32'd195);
        drive(0, 0, 0, 4'b1111);   cycle("indep_end");

        // Reset mid-operation drops buffered words.
        drive(1, 0, 722, 4'b0000); cycle("mid_a");
        drive(1, 3, 275, 4'b0000); cycle("mid_b");
        drive(0, 0, 0, 4'b0000);
        rst_n = 1'b0;
        cycle("mid_rst");
        chk("mid_valid", {28'd0, out_valid}, 32'd0);
        rst_n = 1'b1;
        cycle("mid_after");

`ifdef DEMUX_COUNT_EN
        rst_n = 1'b0; cycle("cnt_rst"); rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 100 + i, 4'b1111);
            cycle("cnt0", 1'b0);
        end
        for (int i = 0; i < 65536; i++) begin
            drive(1, 1, i, 4'b1111);
            cycle("cnt1", 1'b0);
        end
        drive(0, 0, 0, 4'b1111);
        cycle("cnt_drain");
        chk("cnt_ch0", {16'd0, out_count[15:0]}, 32'd3);
        chk("cnt_ch1", {16'd0, out_count[31:16]}, 32'd0);
        rst_n = 1'b0; cycle("cnt_clr"); rst_n = 1'b1;
        chk("cnt_clr_all", out_count[31:0], 32'd0);
`endif

        // Random traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 3),
                  $urandom, 4'($urandom));
            rst_n = ($urandom_range(0, 60) != 0);
            cycle("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
